// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin owner arbitration of the single-port data
// memory between the load/store unit (port 0) and DMA (port 1).
module dmem_arbiter #(
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_rr_ptr;
  logic          w_rr_nxt;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;

  logic          r_rvalid0;
  logic          r_rvalid1;
  logic          r_err0;
  logic          r_err1;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_beat0;
  logic          w_beat1;
  logic          w_beat;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_we;
  logic          w_in_range;
  logic          w_lock;
  logic          w_req_own;
  logic          w_req_oth;
  logic [1:0]    w_oth_state;

  assign w_gnt0 = (r_state == S_OWN0);
  assign w_gnt1 = (r_state == S_OWN1);
  assign w_beat0 = req0 & w_gnt0;
  assign w_beat1 = req1 & w_gnt1;
  assign w_beat = w_beat0 | w_beat1;

  // Owner mux: the non-owner's inputs never reach the memory
  assign w_addr = w_gnt1 ? addr1 : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_we = w_gnt1 ? we1 : we0;
  assign w_in_range = (w_addr < DEPTH_W);

  assign w_lock = w_gnt1 ? lock1 : lock0;
  assign w_req_own = w_gnt1 ? req1 : req0;
  assign w_req_oth = w_gnt1 ? req0 : req1;
  assign w_oth_state = w_gnt1 ? S_OWN0 : S_OWN1;

  assign mem_WE = w_beat & w_we & w_in_range;
  assign mem_A = w_beat ? w_addr : '0;
  assign mem_WD = w_beat ? w_wdata : '0;

  assign w_cnt_inc = (w_beat && r_beat_cnt != MAXC)
                   ? r_beat_cnt + 1'b1 : r_beat_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt = r_rr_ptr;
    w_cnt_nxt = w_cnt_inc;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (req0 && req1)
          w_state_nxt = r_rr_ptr ? S_OWN1 : S_OWN0;
        else if (req0)
          w_state_nxt = S_OWN0;
        else if (req1)
          w_state_nxt = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (!w_lock) begin
          if (!w_req_own) begin
            w_state_nxt = w_req_oth ? w_oth_state : S_IDLE;
            w_rr_nxt = ~w_gnt1;
            w_cnt_nxt = '0;
          end else if (w_cnt_inc == MAXC && w_req_oth) begin
            w_state_nxt = w_oth_state;
            w_rr_nxt = ~w_gnt1;
            w_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr_ptr <= 1'b0;
      r_beat_cnt <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_rvalid0 <= w_beat0 & ~we0;
      r_rvalid1 <= w_beat1 & ~we1;
      r_err0 <= w_beat0 & ~w_in_range;
      r_err1 <= w_beat1 & ~w_in_range;
      if (w_beat0 && !we0)
        r_rdata0 <= w_in_range ? mem_RD : '0;
      if (w_beat1 && !we1)
        r_rdata1 <= w_in_range ? mem_RD : '0;
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign err0 = r_err0;
  assign err1 = r_err1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic checked
// every cycle against an ownership/memory reference model.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;
  localparam int MAXB  = 4;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_WE;
  logic [31:0] mem_A, mem_WD, mem_RD;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in
  logic [31:0] dmem [DEPTH];
  always @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    else if (mem_WE)
      dmem[mem_A[5:0]] <= mem_WD;
  assign mem_RD = (mem_A < 32'(DEPTH)) ? dmem[mem_A[5:0]]
                                       : 32'hBAD0_BAD0;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  bit          busy;
  bit          ow;
  bit          prio;
  int          held;
  bit          e_rv  [2];
  bit          e_err [2];
  logic [31:0] e_rd  [2];
  logic [31:0] shadow [DEPTH];
  bit          ir [2];
  bit          iw [2];
  bit          il [2];
  logic [31:0] ia [2];
  logic [31:0] id [2];

  task automatic mreset();
    busy = 0; ow = 0; prio = 0; held = 0;
    for (int p = 0; p < 2; p++) begin
      e_rv[p] = 0; e_err[p] = 0; e_rd[p] = '0;
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
  endtask

  task automatic mstep();
    bit beat;
    bit y;
    logic [31:0] ad;
    y = !ow;
    beat = busy && ir[ow];
    for (int p = 0; p < 2; p++) begin
      e_rv[p] = 0; e_err[p] = 0;
    end
    if (beat) begin
      ad = ia[ow];
      e_err[ow] = (ad >= 32'(DEPTH));
      e_rv[ow] = !iw[ow];
      if (!iw[ow])
        e_rd[ow] = (ad < 32'(DEPTH)) ? shadow[ad[5:0]] : '0;
      else if (ad < 32'(DEPTH))
        shadow[ad[5:0]] = id[ow];
      held++;
    end
    if (!busy) begin
      if (ir[0] || ir[1]) begin
        busy = 1;
        ow = (ir[0] && ir[1]) ? prio : ir[1];
        held = 0;
      end
    end else if (il[ow]) begin
      busy = 1;
    end else if (!ir[ow]) begin
      prio = y; held = 0; busy = ir[y]; ow = y;
    end else if (held >= MAXB && ir[y]) begin
      prio = y; held = 0; ow = y;
    end
  endtask

  // compare process: outputs vs model each negedge, then advance model
  initial begin
    logic        x_we;
    logic [31:0] x_a, x_wd;
    mreset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mreset();
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_rv0", rvalid0, 1'b0);
        chk1("rst_rv1", rvalid1, 1'b0);
        chk1("rst_err0", err0, 1'b0);
        chk1("rst_err1", err1, 1'b0);
        chk1("rst_we", mem_WE, 1'b0);
        chk32("rst_rd0", rdata0, '0);
        chk32("rst_rd1", rdata1, '0);
      end else begin
        ir[0] = req0; ir[1] = req1; iw[0] = we0; iw[1] = we1;
        il[0] = lock0; il[1] = lock1;
        ia[0] = addr0; ia[1] = addr1; id[0] = wdata0; id[1] = wdata1;
        x_we = 0; x_a = '0; x_wd = '0;
        if (busy && ir[ow]) begin
          x_a = ia[ow];
          x_wd = id[ow];
          x_we = iw[ow] && (ia[ow] < 32'(DEPTH));
        end
        chk1("gnt0", gnt0, busy && !ow);
        chk1("gnt1", gnt1, busy && ow);
        chk1("rvalid0", rvalid0, e_rv[0]);
        chk1("rvalid1", rvalid1, e_rv[1]);
        chk1("err0", err0, e_err[0]);
        chk1("err1", err1, e_err[1]);
        chk32("rdata0", rdata0, e_rd[0]);
        chk32("rdata1", rdata1, e_rd[1]);
        chk1("mem_WE", mem_WE, x_we);
        chk32("mem_A", mem_A, x_a);
        chk32("mem_WD", mem_WD, x_wd);
        mstep();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    quiet();
    tick();
    tick();
    rst_n = 1;
  endtask

  function automatic logic [31:0] raddr();
    int k;
    k = $urandom_range(0, 19);
    if (k < 17) return 32'($urandom_range(0, DEPTH - 1));
    if (k < 19) return 32'(DEPTH + $urandom_range(0, 3));
    return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    rst_n = 0;
    quiet();
    tick();
    tick();
    rst_n = 1;

    // async reset mid-burst
    req0 = 1; we0 = 1; addr0 = 32'd10; wdata0 = 32'h1111;
    tick();
    tick();
    chk1("t1_pre_we", mem_WE, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk1("t1_gnt0", gnt0, 1'b0);
    chk1("t1_we", mem_WE, 1'b0);
    chk1("t1_rv0", rvalid0, 1'b0);
    chk1("t1_err0", err0, 1'b0);
    quiet();
    tick();
    tick();
    rst_n = 1;

    // single port write 3,6,9,12 then read back
    req0 = 1; we0 = 1; addr0 = '0; wdata0 = 32'd3;
    tick();
    chk1("t2_gnt0", gnt0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      addr0 = 32'(i); wdata0 = 32'(3 * (i + 1));
      tick();
      chk1("t2_gnt1", gnt1, 1'b0);
    end
    we0 = 0;
    for (int i = 0; i < 4; i++) begin
      addr0 = 32'(i);
      tick();
      chk1("t2_rv0", rvalid0, 1'b1);
      chk32("t2_rd0", rdata0, 32'(3 * (i + 1)));
    end
    do_reset();

    // contention: 4 beats each, alternating, no idle
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 32'd1; addr1 = 32'd2;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk1("t3_gnt0", gnt0, ((i / 4) % 2) == 0);
      addr0 = raddr(); addr1 = raddr();
      tick();
    end
    do_reset();

    // lock1 holds past burst limit
    req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'd20; wdata1 = 32'hA5;
    tick();
    req0 = 1; we0 = 1; addr0 = 32'd30; wdata0 = 32'h5A;
    for (int k = 0; k < 10; k++) begin
      chk1("t4_gnt0_low", gnt0, 1'b0);
      addr1 = 32'(20 + k);
      tick();
    end
    chk1("t4_gnt1", gnt1, 1'b1);
    lock1 = 0;
    tick();
    chk1("t4_gnt0", gnt0, 1'b1);
    tick();
    do_reset();

    // out-of-range handling on port 1
    req1 = 1; we1 = 1; addr1 = 32'd5; wdata1 = 32'h55;
    tick();
    tick();
    we1 = 0;
    tick();
    chk32("t5_rd_in", rdata1, 32'h55);
    we1 = 1; addr1 = 32'd64; wdata1 = 32'hDEAD;
    #1;
    chk1("t5_we_drop", mem_WE, 1'b0);
    tick();
    chk1("t5_err_w", err1, 1'b1);
    chk1("t5_rv_w", rvalid1, 1'b0);
    we1 = 0;
    tick();
    chk1("t5_err_r", err1, 1'b1);
    chk1("t5_rv_r", rvalid1, 1'b1);
    chk32("t5_rd_oor", rdata1, '0);
    do_reset();

    // request gap drops to idle then re-grants
    req0 = 1; addr0 = 32'd7;
    tick();
    tick();
    req0 = 0;
    tick();
    chk1("t6_idle", gnt0, 1'b0);
    req0 = 1;
    tick();
    chk1("t6_regnt", gnt0, 1'b1);
    do_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      req0 = ($urandom_range(0, 9) < 7);
      req1 = ($urandom_range(0, 9) < 6);
      we0 = $urandom_range(0, 1) == 1;
      we1 = $urandom_range(0, 1) == 1;
      lock0 = ($urandom_range(0, 9) == 0);
      lock1 = ($urandom_range(0, 9) == 0);
      addr0 = raddr(); addr1 = raddr();
      wdata0 = $urandom; wdata1 = $urandom;
      tick();
    end
    quiet();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
